// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Word-addressed data-memory responder behind the control FSM's memory
//   port. Accepts one load/store at a time, waits WAIT_CYC cycles, then
//   emits a single-cycle response pulse (rvalid for loads, wack for stores).
//   Misaligned or out-of-range byte addresses are rejected with err.
//
//   Optional feature macro: MEMRESP_WBUF_EN
//     When defined, stores are posted into a one-entry write buffer and
//     acknowledged in the cycle after accept; the buffer commits to the
//     array on the following edge. When undefined no buffer logic exists.
//
// Parameters
//   ADDR_W   word-address width (array depth = 2**ADDR_W words)
//   DATA_W   data width
//   WAIT_CYC wait states between accept and response (0..15)
//
// Ports
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   req     request valid, accepted when req && ready
//   we      1 = store, 0 = load (sampled with req)
//   addr    byte address
//   wdata   store data
//   ready   responder idle and able to accept
//   rvalid  one-cycle load response pulse
//   rdata   load data, held until the next load response
//   wack    one-cycle store acknowledge pulse
//   err     one-cycle pulse with rvalid/wack when the access was rejected
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              wack,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam bit         NO_WAIT   = (WAIT_CYC == 0);
  // Counter value on the last WAIT cycle; unused when WAIT is never entered.
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYC == 0) ? 0 : (WAIT_CYC - 1));

  // A byte address is rejected when it is not word aligned or addresses
  // beyond the array.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
    return a[ADDR_W+1:2];
  endfunction

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                we_r;
  logic [31:0]         addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                ready_r;
  logic                rvalid_r;
  logic                wack_r;
  logic                err_r;
  logic [DATA_W-1:0]   rdata_r;

  logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

  logic                accept_s;
  logic                fast_path_s;
  logic                enter_resp_s;
  logic                acc_we_s;
  logic [31:0]         acc_addr_s;
  logic [DATA_W-1:0]   acc_wdata_s;
  logic                acc_err_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   load_data_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_widx_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  // ready_r is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept_s = req && ready_r;

`ifdef MEMRESP_WBUF_EN
  logic                wbuf_valid_r;
  logic [ADDR_W-1:0]   wbuf_idx_r;
  logic [DATA_W-1:0]   wbuf_data_r;
  logic                wbuf_load_s;

  // Posted stores skip the wait states entirely.
  assign fast_path_s = NO_WAIT || we;
  assign wbuf_load_s = enter_resp_s && acc_we_s && !acc_err_s;
  assign mem_we_s    = wbuf_valid_r;
  assign mem_widx_s  = wbuf_idx_r;
  assign mem_wdata_s = wbuf_data_r;

  // Load read path with forwarding from an uncommitted buffer entry.
  always_comb begin
    rd_word_s = mem_r[word_idx(acc_addr_s)];
    if (wbuf_valid_r && (wbuf_idx_r == word_idx(acc_addr_s))) begin
      rd_word_s = wbuf_data_r;
    end else begin
      rd_word_s = mem_r[word_idx(acc_addr_s)];
    end
  end

  // One-entry write buffer: filled on a good store response, drained next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_valid_r <= 1'b0;
      wbuf_idx_r   <= {ADDR_W{1'b0}};
      wbuf_data_r  <= {DATA_W{1'b0}};
    end else if (wbuf_load_s) begin
      wbuf_valid_r <= 1'b1;
      wbuf_idx_r   <= word_idx(acc_addr_s);
      wbuf_data_r  <= acc_wdata_s;
    end else if (wbuf_valid_r) begin
      wbuf_valid_r <= 1'b0;
    end
  end
`else
  assign fast_path_s = NO_WAIT;
  assign rd_word_s   = mem_r[word_idx(acc_addr_s)];
  // Stores land in the array on the edge that enters RESP, unless rejected.
  assign mem_we_s    = enter_resp_s && acc_we_s && !acc_err_s;
  assign mem_widx_s  = word_idx(acc_addr_s);
  assign mem_wdata_s = acc_wdata_s;
`endif

  // Access operands: live inputs on the accept edge, latched copies later.
  always_comb begin
    acc_we_s    = we_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      acc_we_s    = we;
      acc_addr_s  = addr;
      acc_wdata_s = wdata;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  assign acc_err_s   = addr_bad(acc_addr_s);
  assign load_data_s = acc_err_s ? {DATA_W{1'b0}} : rd_word_s;

  // Detect the edge on which the FSM moves into RESP.
  always_comb begin
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && fast_path_s) begin
          enter_resp_s = 1'b1;
        end else begin
          enter_resp_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          enter_resp_s = 1'b1;
        end else begin
          enter_resp_s = 1'b0;
        end
      end
      default: enter_resp_s = 1'b0;
    endcase
  end

  // RAM array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Control FSM with registered ready and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      we_r     <= 1'b0;
      addr_r   <= 32'd0;
      wdata_r  <= {DATA_W{1'b0}};
      ready_r  <= 1'b0;
      rvalid_r <= 1'b0;
      wack_r   <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= {DATA_W{1'b0}};
    end else begin
      rvalid_r <= 1'b0;
      wack_r   <= 1'b0;
      err_r    <= 1'b0;
      if (enter_resp_s) begin
        err_r <= acc_err_s;
        if (acc_we_s) begin
          wack_r <= 1'b1;
        end else begin
          rvalid_r <= 1'b1;
          rdata_r  <= load_data_s;
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            we_r    <= we;
            addr_r  <= addr;
            wdata_r <= wdata;
            cnt_r   <= 4'd0;
            ready_r <= 1'b0;
            state_r <= enter_resp_s ? ST_RESP : ST_WAIT;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (enter_resp_s) begin
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign rvalid = rvalid_r;
  assign rdata  = rdata_r;
  assign wack   = wack_r;
  assign err    = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Scoreboard bench for mem_responder (ADDR_W=8, DATA_W=32, WAIT_CYC=2).
//   The stimulus task pushes the expected response for every request; an
//   independent monitor pops and compares whenever rvalid or wack is seen.
//   "Cycle k" of an access is the k-th clock period after its accept edge.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int WAIT_CYC = 2;
  localparam int LD_LAT   = WAIT_CYC + 1;
`ifdef MEMRESP_WBUF_EN
  localparam int ST_LAT   = 1;
`else
  localparam int ST_LAT   = WAIT_CYC + 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              wack;
  logic              err;

  mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .rvalid(rvalid),
    .rdata (rdata),
    .wack  (wack),
    .err   (err)
  );

  typedef struct {
    logic        is_wr;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_resp = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid === 1'b1 || wack === 1'b1) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: actual rvalid=%0b wack=%0b required none (t=%0t)",
                 rvalid, wack, $time);
      end else begin
        e = sb_q.pop_front();
        chk("resp_kind", {30'd0, rvalid, wack}, e.is_wr ? 32'd1 : 32'd2);
        chk("resp_err", {31'd0, err}, {31'd0, e.err});
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.is_wr) chk("rdata", rdata, e.data);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  {31'd0, ready},  32'd0);
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_wack"},   {31'd0, wack},   32'd0);
    chk({tag, "_err"},    {31'd0, err},    32'd0);
    chk({tag, "_rdata"},  rdata,           32'd0);
  endtask

  // Bounded wait (at negedges) for ready.
  task automatic wait_ready();
    int t;
    t = 0;
    while (ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: actual ready=%0b required 1", ready);
    end
  endtask

  // Issue one access from a negedge; push its expected response and check
  // that ready is low until the response cycle and back high right after.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_data, input bit pulse_in_wait);
    int   lat;
    int   acc;
    exp_t e;
    lat = w ? ST_LAT : LD_LAT;
    wait_ready();
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    acc     = cyc;
    e.is_wr = w;
    e.err   = e_err;
    e.data  = e_data;
    e.cyc   = acc + lat - 1;
    sb_q.push_back(e);
    req = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("ready_busy", {31'd0, ready}, 32'd0);
      if (pulse_in_wait && k == 1) req = 1'b1;
      else                         req = 1'b0;
    end
    @(negedge clk);
    chk("ready_back", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int saved_resp;
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;

    // Reset held 3 cycles, outputs all zero.
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("rst");
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, ready}, 32'd1);

    // Store then load back.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Misaligned store rejected; word 0x10 keeps its value.
    issue(1'b1, 32'h13, 32'h12345678, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Out-of-range load with a stray req during WAIT.
    issue(1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b1);

    // Highest valid word, then boundary rejections.
    issue(1'b1, 32'h3FC, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h3FC, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);
    issue(1'b1, 32'h80000010, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h3FD, 32'h0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Reset in cycle 1 of a store to 0x20 must not disturb prior contents.
    issue(1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
    saved_resp = n_resp;
    wait_ready();
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'h11111111;
    @(posedge clk);
    #1;
    req   = 1'b0;
    #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_all_zero("abort");
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, ready}, 32'd1);
    chk("no_resp_on_abort", 32'(n_resp), 32'(saved_resp));
    issue(1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);

    // Store immediately followed by a load of the same word.
    issue(1'b1, 32'h08, 32'h55, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h08, 32'h0, 1'b0, 32'h55, 1'b0);

    repeat (10) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
